// File: rtl/ws_seq_pkg.sv
// ---------------------------------------------------------------------------
// ws_seq_pkg
// Shared definitions for the weight-stationary memory sequencer:
//   - seq_state_t    : controller phase encoding
//   - SEQ_* defaults : default array geometry and element width
//   - MEM_PORT_WIDTH : BRAM port width for the default geometry
//   - default_in_base / default_out_base : default BRAM region bases
// No ports (package).
// ---------------------------------------------------------------------------
package ws_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        WRITE
    } seq_state_t;

    localparam int SEQ_ROWS       = 4;
    localparam int SEQ_COLS       = 4;
    localparam int SEQ_WORD_SIZE  = 16;
    localparam int MEM_PORT_WIDTH = SEQ_COLS * SEQ_WORD_SIZE;

    // Staggered input lines sit directly after the weight rows.
    function automatic int unsigned default_in_base(input int unsigned rows);
        return rows;
    endfunction

    // Output lines follow the ROWS+COLS-1 staggered input lines.
    function automatic int unsigned default_out_base(input int unsigned rows,
                                                     input int unsigned cols);
        return 2 * rows + cols - 1;
    endfunction

endpackage

// File: rtl/seq_result_fifo.sv
// ---------------------------------------------------------------------------
// seq_result_fifo
// Small synchronous FIFO that parks SA result rows until the BRAM port is
// free. A push while full is accepted only if a pop happens in the same
// cycle; otherwise the push is dropped (the caller flags the overflow).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous flush (new run)
//   push      : write wr_data
//   pop       : discard head entry
//   wr_data   : entry to push
//   rd_data   : head entry (valid while !empty)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : current occupancy
// ---------------------------------------------------------------------------
module seq_result_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is fine then.
    assign do_push = push && !clr && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ws_mem_sequencer.sv
// ---------------------------------------------------------------------------
// ws_mem_sequencer
// Drives the single-port matrix BRAM for a weight-stationary systolic array:
// loads ROWS weight rows, streams ROWS+COLS-1 pre-staggered input lines, then
// writes the COLS buffered result rows back to the output region. Results
// arriving while reads are still in flight are parked in seq_result_fifo so
// reads and writes never share a cycle.
// Optional feature: define SEQ_CYCLE_CNT_EN to add cycle_cnt[31:0], the
// number of busy cycles of the latest run.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : run request, ignored while busy
//   busy, done    : run in progress / last write issued (one-cycle pulse)
//   err           : sticky result-FIFO overflow
//   mem_we, mem_addr, mem_di, mem_dout : BRAM port (1-cycle read latency)
//   w_load, w_row : weight-row load strobe and row index
//   sa_in_valid   : input-line strobe
//   sa_data       : weight row or input line forwarded from mem_dout
//   sa_out_valid, sa_out_data : SA result rows
//   cycle_cnt     : busy-cycle count (SEQ_CYCLE_CNT_EN only)
// ---------------------------------------------------------------------------
module ws_mem_sequencer
    import ws_seq_pkg::*;
#(
    parameter  int          ROWS       = SEQ_ROWS,
    parameter  int          COLS       = SEQ_COLS,
    parameter  int          WORD_SIZE  = SEQ_WORD_SIZE,
    parameter  int          ADDR_WIDTH = 32,
    parameter  int unsigned W_BASE     = 0,
    parameter  int unsigned IN_BASE    = default_in_base(ROWS),
    parameter  int unsigned OUT_BASE   = default_out_base(ROWS, COLS),
    localparam int          PORT_W     = COLS * WORD_SIZE,
    localparam int          RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [PORT_W-1:0]     mem_di,
    input  logic [PORT_W-1:0]     mem_dout,
    output logic                  w_load,
    output logic [RW-1:0]         w_row,
    output logic                  sa_in_valid,
    output logic [PORT_W-1:0]     sa_data,
    input  logic                  sa_out_valid,
    input  logic [PORT_W-1:0]     sa_out_data
`ifdef SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycle_cnt
`endif
);

    localparam int CW  = $clog2(ROWS + COLS + 1);
    localparam int FCW = $clog2(COLS + 1);

    localparam logic [CW-1:0]  LAST_W     = CW'(ROWS - 1);
    localparam logic [CW-1:0]  LAST_IN    = CW'(ROWS + COLS - 2);
    localparam logic [CW-1:0]  STREAM_END = CW'(ROWS + COLS - 1);
    localparam logic [CW-1:0]  LAST_OUT   = CW'(COLS - 1);
    localparam logic [FCW-1:0] FULL_CNT   = FCW'(COLS);

    localparam logic [ADDR_WIDTH-1:0] W_ADDR   = ADDR_WIDTH'(W_BASE);
    localparam logic [ADDR_WIDTH-1:0] IN_ADDR  = ADDR_WIDTH'(IN_BASE);
    localparam logic [ADDR_WIDTH-1:0] OUT_ADDR = ADDR_WIDTH'(OUT_BASE);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [FCW-1:0]   fcount;
    logic [PORT_W-1:0] head;

    assign accept = start && (state == IDLE);
    assign push   = sa_out_valid && (state != IDLE);

    seq_result_fifo #(
        .DEPTH (COLS),
        .WIDTH (PORT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .push    (push),
        .pop     (pop),
        .wr_data (sa_out_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fcount)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)              state_nxt = LOAD_W;
            LOAD_W:  if (cnt == LAST_W)      state_nxt = STREAM;
            // One extra cycle after the last read so its data reaches the SA.
            STREAM:  if (cnt == STREAM_END)  state_nxt = DRAIN;
            DRAIN:   if (fcount == FULL_CNT) state_nxt = WRITE;
            WRITE:   if (cnt == LAST_OUT)    state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy   = (state != IDLE);
        mem_we = 1'b0;
        done   = 1'b0;
        pop    = 1'b0;
        mem_di = '0;
        if (state == WRITE) begin
            mem_we = 1'b1;
            pop    = !empty;
            mem_di = head;
            done   = (cnt == LAST_OUT);
        end
        sa_data = (w_load || sa_in_valid) ? mem_dout : '0;
    end

    // Address / phase counter and read-data strobes (one cycle behind the address)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= '0;
            cnt         <= '0;
            w_load      <= 1'b0;
            w_row       <= '0;
            sa_in_valid <= 1'b0;
        end else begin
            w_load      <= (state == LOAD_W);
            sa_in_valid <= (state == STREAM) && (cnt <= LAST_IN);
            if (state == LOAD_W) w_row <= cnt[RW-1:0];
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= W_ADDR;
                        cnt      <= '0;
                    end
                end
                LOAD_W: begin
                    if (cnt == LAST_W) begin
                        mem_addr <= IN_ADDR;
                        cnt      <= '0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        cnt      <= cnt + CW'(1);
                    end
                end
                STREAM: begin
                    if (cnt == STREAM_END) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt != LAST_IN) mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (fcount == FULL_CNT) begin
                        mem_addr <= OUT_ADDR;
                        cnt      <= '0;
                    end
                end
                WRITE: begin
                    if (cnt == LAST_OUT) begin
                        cnt <= '0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        cnt      <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow: a push into a full FIFO with no pop that cycle is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      err <= 1'b0;
        else if (accept)              err <= 1'b0;
        else if (push && full && !pop) err <= 1'b1;
    end

`ifdef SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cycle_cnt <= '0;
        else if (accept) cycle_cnt <= '0;
        else if (busy)   cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ws_mem_sequencer.sv
module tb_ws_mem_sequencer;
    import ws_seq_pkg::*;

    localparam int          ROWS       = 4;
    localparam int          COLS       = 4;
    localparam int          WORD_SIZE  = 16;
    localparam int          ADDR_WIDTH = 32;
    localparam int          PW         = COLS * WORD_SIZE;
    localparam int unsigned W_BASE     = 0;
    localparam int unsigned IN_BASE    = 4;
    localparam int unsigned OUT_BASE   = 11;
    // Cycle (after the start cycle t0) on which the last write / done occurs.
    localparam int          T_DONE     = 17;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [PW-1:0]         mem_di;
    logic [PW-1:0]         mem_dout;
    logic                  w_load;
    logic [1:0]            w_row;
    logic                  sa_in_valid;
    logic [PW-1:0]         sa_data;
    logic                  sa_out_valid;
    logic [PW-1:0]         sa_out_data;
`ifdef SEQ_CYCLE_CNT_EN
    logic [31:0]           cycle_cnt;
`endif

    int n_assert;
    int n_fail;

    logic [31:0]   exp_addr[$];
    logic [PW-1:0] exp_data[$];

    ws_mem_sequencer #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .W_BASE     (W_BASE),
        .IN_BASE    (IN_BASE),
        .OUT_BASE   (OUT_BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_di       (mem_di),
        .mem_dout     (mem_dout),
        .w_load       (w_load),
        .w_row        (w_row),
        .sa_in_valid  (sa_in_valid),
        .sa_data      (sa_data),
        .sa_out_valid (sa_out_valid),
        .sa_out_data  (sa_out_data)
`ifdef SEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM content is a function of the address so read data is predictable.
    function automatic logic [PW-1:0] pat(input logic [31:0] a);
        return {16'hDA7A, a[15:0], ~a[15:0], 16'h5A5A};
    endfunction

    // SA result row k: 0x1111.. for k=0, 0x2222.. for k=1, ...
    function automatic logic [PW-1:0] rowpat(input int k);
        return 64'h1111_1111_1111_1111 * 64'(k + 1);
    endfunction

    always @(posedge clk) mem_dout <= pat(mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One run: start in t0, SA stub returns n_res rows from cycle first_res,
    // optional extra start pulse at restart_t, optional reset at rst_t.
    task automatic run_seq(input int first_res, input int n_res, input int restart_t,
                           input int rst_t, input bit exp_err);
        int            pushed;
        int            k;
        logic [31:0]   ea;
        logic [PW-1:0] ed;
        pushed = 0;
        exp_addr.delete();
        exp_data.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= T_DONE; t++) begin
            k            = t - first_res;
            sa_out_valid = (k >= 0) && (k < n_res);
            sa_out_data  = sa_out_valid ? rowpat(k) : '0;
            if (sa_out_valid && pushed < COLS) begin
                exp_addr.push_back(32'(OUT_BASE) + 32'(pushed));
                exp_data.push_back(rowpat(k));
                pushed++;
            end
            start = (t == restart_t);
            if (t == rst_t) begin
                rst = 1'b1;
                #1;
                check("rst_mem_we", 64'(mem_we), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_state", 64'(dut.state), 64'(IDLE));
                rst          = 1'b0;
                start        = 1'b0;
                sa_out_valid = 1'b0;
                tick();
                check("rst_stays_idle", 64'(busy), 64'd0);
                return;
            end
            check("busy", 64'(busy), 64'(1));
            if (t <= 4)       check("w_addr", 64'(mem_addr), 64'(W_BASE + 32'(t - 1)));
            else if (t <= 11) check("in_addr", 64'(mem_addr), 64'(IN_BASE + 32'(t - 5)));
            check("w_load", 64'(w_load), 64'(t >= 2 && t <= 5));
            if (t >= 2 && t <= 5) begin
                check("w_row", 64'(w_row), 64'(t - 2));
                check("w_data", 64'(sa_data), 64'(pat(W_BASE + 32'(t - 2))));
            end
            check("sa_in_valid", 64'(sa_in_valid), 64'(t >= 6 && t <= 12));
            if (t >= 6 && t <= 12) check("in_data", 64'(sa_data), 64'(pat(IN_BASE + 32'(t - 6))));
            check("mem_we", 64'(mem_we), 64'(t >= 14 && t <= 17));
            check("done", 64'(done), 64'(t == T_DONE));
            if (t == 1) check("err_cleared", 64'(err), 64'd0);
            if (mem_we) begin
                check("sb_has_entry", 64'(exp_addr.size() != 0), 64'd1);
                if (exp_addr.size() != 0) begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(ea));
                    check("wr_data", 64'(mem_di), 64'(ed));
                end
            end
            tick();
        end
        start        = 1'b0;
        sa_out_valid = 1'b0;
        sa_out_data  = '0;
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_after", 64'(done), 64'd0);
        check("addr_hold", 64'(mem_addr), 64'(OUT_BASE + COLS - 1));
        check("err_final", 64'(err), 64'(exp_err));
        check("sb_drained", 64'(exp_addr.size()), 64'd0);
`ifdef SEQ_CYCLE_CNT_EN
        check("cycle_cnt", 64'(cycle_cnt), 64'd17);
`endif
        tick();
        tick();
        check("idle_we", 64'(mem_we), 64'd0);
        check("idle_addr_hold", 64'(mem_addr), 64'(OUT_BASE + COLS - 1));
`ifdef SEQ_CYCLE_CNT_EN
        check("cycle_cnt_hold", 64'(cycle_cnt), 64'd17);
`endif
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        sa_out_valid = 1'b0;
        sa_out_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        check("reset_mem_di", 64'(mem_di), 64'd0);
        check("reset_w_load", 64'(w_load), 64'd0);
        check("reset_w_row", 64'(w_row), 64'd0);
        check("reset_sa_in_valid", 64'(sa_in_valid), 64'd0);
        check("reset_sa_data", 64'(sa_data), 64'd0);
        check("reset_state", 64'(dut.state), 64'(IDLE));
        rst = 1'b0;
        tick();

        // Basic run: results at t9..t12
        run_seq(9, 4, 0, 0, 1'b0);
        // Overlap: all results during STREAM
        run_seq(6, 4, 0, 0, 1'b0);
        // Overflow: five results, start pulsed during WRITE must not clear err
        run_seq(8, 5, 14, 0, 1'b1);
        // Start while busy during STREAM; accepted start clears the old err
        run_seq(9, 4, 7, 0, 1'b0);
        // Reset mid-STREAM
        run_seq(9, 4, 0, 7, 1'b0);
        // Full run after the reset
        run_seq(9, 4, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ws_mem_sequencer.md
Name: ws_mem_sequencer

Overview:
- Controls the single-port matrix BRAM (port width MEM_PORT_WIDTH) for a weight-stationary systolic array (SA).
- On `start` it runs three phases:
  - Reads the weight rows into the SA.
  - Streams the pre-staggered input lines into the SA.
  - Collects the SA result rows and writes them back to the BRAM output region.
- SA results appear while inputs are still streaming, but the BRAM has one port. The block buffers results in an internal FIFO and arbitrates the port: reads first, then write-back.

Parameters:
- ROWS, 4, SA rows; number of weight lines.
- COLS, 4, SA columns; number of output lines.
- WORD_SIZE, 16, bits per matrix element.
- ADDR_WIDTH, 32, BRAM address width.
- W_BASE, 0, first weight line address.
- IN_BASE, ROWS, first staggered-input line address; ROWS+COLS-1 lines are read.
- OUT_BASE, 2*ROWS+COLS-1, first output line address; COLS lines are written.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last output write is issued.
- err  out  1  sticky result-FIFO overflow flag; cleared by rst or an accepted start.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_di  out  MEM_PORT_WIDTH  BRAM write data.
- mem_dout  in  MEM_PORT_WIDTH  BRAM registered read data; valid 1 cycle after mem_addr.
- w_load  out  1  SA weight-row load strobe.
- w_row  out  clog2(ROWS)  weight row index.
- sa_in_valid  out  1  SA input line valid.
- sa_data  out  MEM_PORT_WIDTH  shared data to the SA (weight row or input line).
- sa_out_valid  in  1  SA result row valid.
- sa_out_data  in  MEM_PORT_WIDTH  SA result row.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; err 0.
- An asynchronous rst mid-run forces mem_we=0 immediately and discards the run.
- States:
  - IDLE → LOAD_W on start.
  - LOAD_W: issue reads W_BASE..W_BASE+ROWS-1, one per cycle. Each mem_dout is forwarded with w_load=1 and w_row=k, 1 cycle after its address. After the last issue → STREAM.
  - STREAM: issue reads IN_BASE..IN_BASE+ROWS+COLS-2 back-to-back, with no gap after LOAD_W. Each returned line is driven with sa_in_valid=1 one cycle later. After the last issue plus 1 cycle (its data delivered) → DRAIN.
  - DRAIN: wait until the FIFO holds COLS entries → WRITE.
  - WRITE: pop one entry per cycle; mem_we=1, mem_addr=OUT_BASE+k, mem_di=entry, for k=0..COLS-1. On the last write assert done=1 (same cycle) → IDLE.
- busy deasserts in the cycle after done.
- mem_we is 0 in every state except WRITE.
- FIFO:
  - Depth COLS.
  - Pushes sa_out_data when sa_out_valid=1, in any state except IDLE.
  - A push while full drops the data and sets err.
  - Push and pop in the same cycle (WRITE) is legal; occupancy is unchanged.
- Read latency is exactly 1 cycle and the controller never stalls the SA.
- mem_addr increments by 1 per cycle with no wrap. Address arithmetic is ADDR_WIDTH unsigned.
- mem_addr holds its last value in IDLE.
- start while busy: ignored, with no effect on err.
- Total run length with no backpressure: ROWS + (ROWS+COLS-1) + 1 + drain wait + COLS cycles.

Optional Feature:
- Macro: SEQ_CYCLE_CNT_EN.
- Defined: adds output cycle_cnt [31:0].
  - Cleared on an accepted start.
  - Increments every cycle busy=1.
  - Holds after done; reset value 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ws_seq_pkg:
  - state enum seq_state_t {IDLE, LOAD_W, STREAM, DRAIN, WRITE}.
  - localparam MEM_PORT_WIDTH = COLS*WORD_SIZE.
  - Address-region base helpers.
- One sub-module: seq_result_fifo, a synchronous FIFO with parameters DEPTH=COLS and WIDTH=MEM_PORT_WIDTH, ports push/pop/full/empty/count, and asynchronous active-high rst.

Test Plan:
- Basic run, 4x4: start at t0.
  - Weight reads: mem_addr 0,1,2,3 at t1..t4.
  - Input reads: addr 4..10 at t5..t11.
  - w_load pulses t2..t5 with w_row 0..3.
  - sa_in_valid t6..t12.
  - Stub SA returns rows 0x11..,0x22..,0x33..,0x44.. at t9..t12.
  - Required: writes to addr 11..14 in order, done pulses once on the addr-14 write.
- Overlap: SA returns all 4 rows during STREAM → no write occurs until STREAM ends; mem_we never coincides with a read.
- Overflow: stub SA returns 5 rows → err=1 and only the first 4 rows are written. A second start clears err.
- start pulsed while busy → no restart; address sequence unchanged. After done, a new start replays the sequence from addr 0.
- rst asserted mid-STREAM → the same cycle has mem_we=0, busy=0, state IDLE. The next start runs a full sequence correctly.
- With SEQ_CYCLE_CNT_EN defined and results arriving at t9..t12: cycle_cnt equals busy cycles (17 for the basic run) and holds after done. The build without the macro compiles and has no cycle_cnt port.
